// File: rtl/mmio_bus_bridge.sv
// Single-register MMIO bridge: CPU valid/ready request in, one-beat response out.
// Define MMIO_BYTE_STROBE_EN to enable read-merge-write for partial byte strobes.
module mmio_bus_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        periph_write_en,
  output logic [31:0] periph_addr,
  output logic [31:0] periph_write_data,
  input  logic [31:0] periph_read_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MERGE  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]  state;
  logic        ready_en;
  logic        accept;
  logic        we_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

`ifdef MMIO_BYTE_STROBE_EN
  logic [3:0]  wstrb_p0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] wr,
                                              input logic [31:0] rd,
                                              input logic [3:0]  strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = strb[b] ? wr[8*b +: 8] : rd[8*b +: 8];
    return m;
  endfunction
`endif

  assign req_ready = (state == IDLE) && ready_en;
  assign accept    = req_valid && req_ready;

  // request capture stage: data registers carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
`ifdef MMIO_BYTE_STROBE_EN
      wstrb_p0 <= req_wstrb;
    end else if (state == MERGE) begin
      wdata_p0 <= merge_bytes(wdata_p0, periph_read_data, wstrb_p0);
`endif
    end
  end

  // control stage: sequencing and the registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_addr != BASE_ADDR) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_we && (req_wstrb == 4'h0)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= 32'h0;
`ifdef MMIO_BYTE_STROBE_EN
            end else if (req_we && (req_wstrb != 4'hF)) begin
              state <= MERGE;
`endif
            end else begin
              state <= ACCESS;
            end
          end
        end
        MERGE:  state <= ACCESS;
        ACCESS: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= we_p0 ? 32'h0 : periph_read_data;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // peripheral port: a write abandoned by reset in its ACCESS cycle never reaches the register
  assign periph_write_en   = (state == ACCESS) && we_p0 && rst_n;
  assign periph_addr       = ((state == MERGE) || (state == ACCESS)) ? addr_p0 : 32'h0;
  assign periph_write_data = ((state == ACCESS) && we_p0) ? wdata_p0 : 32'h0;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge: directed scenarios plus randomized
// transactions against a transaction-level model of the bridge and its register.
module tb_mmio_bus_bridge;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        periph_write_en;
  logic [31:0] periph_addr;
  logic [31:0] periph_write_data;
  logic [31:0] periph_read_data;

  int          errs   = 0;
  int          checks = 0;
  int          pulse_cnt = 0;
  logic [31:0] periph_reg = 32'h0;
  logic [31:0] model_reg  = 32'h0;
  logic        preload_req = 1'b0;
  logic [31:0] preload_val = 32'h0;

  mmio_bus_bridge #(.BASE_ADDR(BASE)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_wstrb         (req_wstrb),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .periph_write_en   (periph_write_en),
    .periph_addr       (periph_addr),
    .periph_write_data (periph_write_data),
    .periph_read_data  (periph_read_data)
  );

  always #5 clk = ~clk;

  // downstream register
  assign periph_read_data = (periph_addr == BASE) ? periph_reg : 32'h0;
  always @(posedge clk) begin
    if (preload_req) periph_reg <= preload_val;
    else if (periph_write_en) begin
      periph_reg <= periph_write_data;
      pulse_cnt  <= pulse_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk);
    preload_req = 1'b1;
    preload_val = v;
    @(posedge clk);
    #1 preload_req = 1'b0;
    model_reg = v;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int hold);
    int          exp_lat;
    int          exp_pulses;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    int          p0;
    logic [31:0] r_hold;
    logic        e_hold;

    exp_err    = (addr != BASE);
    exp_rdata  = 32'h0;
    exp_pulses = 0;
    if (exp_err) exp_lat = 1;
    else if (!we) begin
      exp_lat   = 2;
      exp_rdata = model_reg;
    end else if (strb == 4'h0) exp_lat = 1;
    else begin
      exp_pulses = 1;
`ifdef MMIO_BYTE_STROBE_EN
      if (strb != 4'hF) begin
        exp_lat = 3;
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_reg[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_lat   = 2;
        model_reg = wdata;
      end
`else
      exp_lat   = 2;
      model_reg = wdata;
`endif
    end

    @(negedge clk);
    chk("rdy_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    rsp_ready = 1'b0;
    p0 = pulse_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 8);
    chk("latency", lat, exp_lat);
    chk("rdata", rsp_rdata, exp_rdata);
    chk("err", {31'b0, rsp_err}, {31'b0, exp_err});
    chk("rdy_busy", {31'b0, req_ready}, 32'd0);
    r_hold = rsp_rdata;
    e_hold = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = BASE;
      req_wdata = $urandom;
      req_wstrb = 4'hF;
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, r_hold);
      chk("hold_err", {31'b0, rsp_err}, {31'b0, e_hold});
      chk("hold_rdy", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("pulses", pulse_cnt - p0, exp_pulses);
    chk("reg", periph_reg, model_reg);
    @(negedge clk);
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
    chk("rdy_back", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [6];
    int          p0;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    rsp_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_wen", {31'b0, periph_write_en}, 32'd0);
    chk("rst_paddr", periph_addr, 32'h0);
    chk("rst_pwdata", periph_write_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel_rdy", {31'b0, req_ready}, 32'd1);

    // read of a zero register, then full write and readback
    preload(32'h0);
    run_txn(1'b0, BASE, 32'h0, 4'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wen_t1", {31'b0, periph_write_en}, 32'd1);
    chk("wdata_t1", periph_write_data, 32'hDEAD_BEEF);
    chk("paddr_t1", periph_addr, BASE);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("wen_t2", {31'b0, periph_write_en}, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    model_reg = 32'hDEAD_BEEF;
    run_txn(1'b0, BASE, 32'h0, 4'h0, 0);

    // partial strobe write
    preload(32'h1122_3344);
    run_txn(1'b1, BASE, 32'hAABB_CCDD, 4'b0101, 0);
`ifdef MMIO_BYTE_STROBE_EN
    chk("merge_val", periph_reg, 32'h11BB_33DD);
`else
    chk("full_val", periph_reg, 32'hAABB_CCDD);
`endif

    // zero-strobe write, decode errors, held response
    run_txn(1'b1, BASE, 32'h0BAD_F00D, 4'h0, 0);
    run_txn(1'b0, BASE + 32'd4, 32'h0, 4'h0, 0);
    run_txn(1'b1, BASE + 32'd1, 32'hFFFF_FFFF, 4'hF, 0);
    run_txn(1'b0, BASE, 32'h0, 4'h0, 5);

    // reset during the ACCESS cycle of a write
    preload(32'h5555_AAAA);
    p0 = pulse_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rdy", {31'b0, req_ready}, 32'd0);
    chk("mid_valid", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("mid_rel_rdy", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    chk("mid_reg", periph_reg, 32'h5555_AAAA);
    chk("mid_pulses", pulse_cnt - p0, 0);

    // randomized traffic
    addrs[0] = BASE;         addrs[1] = BASE;
    addrs[2] = BASE + 32'd4; addrs[3] = BASE + 32'd2;
    addrs[4] = BASE + 32'd3; addrs[5] = 32'h0;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = addrs[$urandom_range(0, 5)];
      if (a == 32'h0) a = $urandom;
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mmio_bus_bridge.md
MMIO_BUS_BRIDGE -- requirements
Module: mmio_bus_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter BASE_ADDR, default 32'h4000_0000, SHALL be the single decoded word address of the downstream register.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  CPU request present.
REQ-006 req_ready  out  1  bridge can accept a request.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  write data.
REQ-010 req_wstrb  in  4  byte-lane enables; bit i covers bits [8i+7:8i].
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  CPU accepts the response.
REQ-013 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-014 rsp_err  out  1  decode error.
REQ-015 periph_write_en  out  1  one-cycle write pulse to the register.
REQ-016 periph_addr  out  32  address to the register.
REQ-017 periph_write_data  out  32  write data to the register.
REQ-018 periph_read_data  in  32  combinational read data from the register for periph_addr.

Function
REQ-019 The FSM SHALL have states IDLE, MERGE, ACCESS and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, and req_we/addr/wdata/wstrb SHALL be captured on that edge.
REQ-021 Decode error: if captured addr != BASE_ADDR (this covers addr[1:0] != 0), the FSM SHALL go IDLE -> RESP with rsp_err=1 and rsp_rdata=0, and SHALL drive no periph_write_en.
REQ-022 Read: IDLE -> ACCESS -> RESP; in ACCESS, periph_rdata SHALL be registered from periph_read_data into rsp_rdata.
REQ-023 Write with wstrb=4'hF: IDLE -> ACCESS -> RESP; periph_write_en SHALL be 1 for exactly the ACCESS cycle, with periph_write_data = captured wdata.
REQ-024 Write with wstrb=0 and a valid address: IDLE -> RESP with rsp_err=0 and no write pulse.
REQ-025 Write with partial wstrb: behaviour SHALL be as defined under Configuration.
REQ-026 periph_addr SHALL equal the captured addr in MERGE and ACCESS, and 0 otherwise; periph_write_en SHALL be 0 outside ACCESS.
REQ-027 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-028 Latency from the accept edge T to first rsp_valid SHALL be:
- T+2 for full access;
- T+1 for error or wstrb=0;
- T+3 with MERGE.
REQ-029 At most one transaction SHALL be outstanding; there is no back-to-back acceptance while in RESP.

Reset
REQ-030 While rst_n=0 at a clock edge:
- state SHALL go to IDLE;
- rsp_valid, rsp_rdata, rsp_err, periph_write_en, periph_addr and periph_write_data SHALL become 0;
- req_ready SHALL be 0 in the cycle reset is asserted, and 1 from the first edge with rst_n=1.
REQ-031 Reset sampled mid-transaction SHALL abandon it, with no write pulse and no response in the cycles that follow.

Configuration
REQ-032 Macro MMIO_BYTE_STROBE_EN, when defined, SHALL make a partial-strobe write go IDLE -> MERGE -> ACCESS -> RESP. In MERGE, the bridge SHALL latch the value merged per byte: req byte if its strobe bit is 1, else the periph_read_data byte. ACCESS SHALL then write that merged value.
REQ-033 With MMIO_BYTE_STROBE_EN undefined, MERGE SHALL not exist, and any nonzero wstrb SHALL be treated as 4'hF (full-word write of wdata).

Verification
REQ-034 Reset, then a read of 0x4000_0000 with the register holding 0 -> rsp_valid at T+2, rdata=0, err=0.
REQ-035 Write 0xDEAD_BEEF, wstrb=F, to 0x4000_0000, then read it back -> exactly one periph_write_en pulse at T+1; the read returns 0xDEAD_BEEF.
REQ-036 With the macro defined, the register holds 0x1122_3344 and a write of 0xAABB_CCDD with wstrb=4'b0101 is issued -> the register becomes 0x11BB_33DD and rsp_valid is at T+3. With the macro undefined, the same write gives 0xAABB_CCDD at T+2.
REQ-037 Accesses to 0x4000_0004 and 0x4000_0001 -> err=1, rdata=0, no periph_write_en, rsp_valid at T+1.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay stable, req_ready=0 throughout, and a new request is accepted only after the rsp_ready handshake.
REQ-039 Assert rst_n=0 in the ACCESS cycle of a write -> the register is unchanged, no response follows, and req_ready=1 on the first edge after release.
